// File: rtl/keypad_lcd_writer.sv
// Keypad-to-LCD writer: queues 4-bit key codes and writes them as characters to an
// HD44780-style LCD in 8-bit mode, with RS/E/DATA timing and two-line cursor tracking.
module keypad_lcd_writer #(
  parameter int E_PULSE    = 12,
  parameter int CHAR_WAIT  = 2000,
  parameter int CLR_WAIT   = 80000,
  parameter int FIFO_DEPTH = 4,
  parameter int LINE_LEN   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       overflow,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       cur_line,
  output logic [4:0] cur_col
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int MAX_T = (CLR_WAIT > CHAR_WAIT)
                         ? ((CLR_WAIT > E_PULSE) ? CLR_WAIT : E_PULSE)
                         : ((CHAR_WAIT > E_PULSE) ? CHAR_WAIT : E_PULSE);
  localparam int TW    = $clog2(MAX_T + 1);

  typedef logic [TW-1:0] tcnt_t;
  localparam tcnt_t          E_LAST    = tcnt_t'(E_PULSE - 1);
  localparam tcnt_t          CHAR_LAST = tcnt_t'(CHAR_WAIT - 1);
  localparam tcnt_t          CLR_LAST  = tcnt_t'(CLR_WAIT - 1);
  localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [4:0]     LINE_C    = 5'(LINE_LEN);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ADDR, S_SETUP, S_PULSE, S_HOLD} state_t;
  typedef enum logic [1:0] {W_CHAR, W_ADDR, W_CLR} kind_t;

  state_t state, n_state;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;
  logic [3:0]    head;

  assign key_ready = !rst && (count != DEPTH_C);
  assign push      = key_valid && key_ready;
  assign pop       = (state == S_LOAD);
  assign head      = mem[rd_ptr];
  assign busy      = (state != S_IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= key_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      overflow <= key_valid && !key_ready;
    end
  end

  function automatic logic [7:0] key_char(input logic [3:0] k);
    if (k <= 4'd9)      return {4'h3, k};
    else if (k == 4'hE) return 8'h2A;
    else                return 8'h37 + {4'h0, k};
  endfunction

  tcnt_t      tcnt, n_tcnt, hold_len, n_hold;
  kind_t      kind, n_kind;
  logic       pend, n_pend;
  logic [7:0] pend_data, n_pend_data;
  logic       n_rs, n_e, n_line;
  logic [7:0] n_data;
  logic [4:0] n_col;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      hold_len  <= '0;
      kind      <= W_CHAR;
      pend      <= 1'b0;
      pend_data <= '0;
      lcd_rs    <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_data  <= '0;
      cur_line  <= 1'b0;
      cur_col   <= '0;
    end else begin
      state     <= n_state;
      tcnt      <= n_tcnt;
      hold_len  <= n_hold;
      kind      <= n_kind;
      pend      <= n_pend;
      pend_data <= n_pend_data;
      lcd_rs    <= n_rs;
      lcd_e     <= n_e;
      lcd_data  <= n_data;
      cur_line  <= n_line;
      cur_col   <= n_col;
    end
  end

  always_comb begin
    n_state     = state;
    n_tcnt      = tcnt;
    n_hold      = hold_len;
    n_kind      = kind;
    n_pend      = pend;
    n_pend_data = pend_data;
    n_rs        = lcd_rs;
    n_e         = lcd_e;
    n_data      = lcd_data;
    n_line      = cur_line;
    n_col       = cur_col;
    unique case (state)
      S_IDLE: begin
        if (count != '0) n_state = S_LOAD;
      end
      S_LOAD: begin
        if (head == 4'hF) begin
          n_rs    = 1'b0;
          n_data  = 8'h01;
          n_kind  = W_CLR;
          n_hold  = CLR_LAST;
          n_state = S_SETUP;
        end else if (cur_col == LINE_C) begin
          // Full line: park the character and move the cursor first.
          n_pend      = 1'b1;
          n_pend_data = key_char(head);
          n_state     = S_ADDR;
        end else begin
          n_rs    = 1'b1;
          n_data  = key_char(head);
          n_kind  = W_CHAR;
          n_hold  = CHAR_LAST;
          n_state = S_SETUP;
        end
      end
      S_ADDR: begin
        n_rs    = 1'b0;
        n_data  = cur_line ? 8'h80 : 8'hC0;
        n_kind  = W_ADDR;
        n_hold  = CHAR_LAST;
        n_state = S_SETUP;
      end
      S_SETUP: begin
        n_e     = 1'b1;
        n_tcnt  = E_LAST;
        n_state = S_PULSE;
      end
      S_PULSE: begin
        if (tcnt == '0) begin
          n_e     = 1'b0;
          n_tcnt  = hold_len;
          n_state = S_HOLD;
        end else begin
          n_tcnt = tcnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (tcnt == '0) begin
          unique case (kind)
            W_CLR:  begin n_line = 1'b0;      n_col = '0; end
            W_ADDR: begin n_line = !cur_line; n_col = '0; end
            default: n_col = cur_col + 5'd1;
          endcase
          if (pend) begin
            n_rs    = 1'b1;
            n_data  = pend_data;
            n_kind  = W_CHAR;
            n_hold  = CHAR_LAST;
            n_pend  = 1'b0;
            n_state = S_SETUP;
          end else if (count != '0) begin
            n_state = S_LOAD;
          end else begin
            n_state = S_IDLE;
          end
        end else begin
          n_tcnt = tcnt - 1'b1;
        end
      end
      default: n_state = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_keypad_lcd_writer.sv
// Bench for keypad_lcd_writer: translation table, timing/corner sequences and
// randomized key streams checked against a queue-based model of the LCD writes.
module tb_keypad_lcd_writer;
  localparam int E_PULSE    = 2;
  localparam int CHAR_WAIT  = 5;
  localparam int CLR_WAIT   = 20;
  localparam int FIFO_DEPTH = 4;
  localparam int LINE_LEN   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_code = '0;
  logic       key_valid = 1'b0;
  logic       key_ready, overflow, busy, lcd_rs, lcd_e, cur_line;
  logic [7:0] lcd_data;
  logic [4:0] cur_col;

  int tests = 0;
  int fails = 0;

  logic [8:0] got[$];
  logic [8:0] exp_q[$];
  int         m_line = 0;
  int         m_col  = 0;

  keypad_lcd_writer #(
    .E_PULSE(E_PULSE), .CHAR_WAIT(CHAR_WAIT), .CLR_WAIT(CLR_WAIT),
    .FIFO_DEPTH(FIFO_DEPTH), .LINE_LEN(LINE_LEN)
  ) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .key_ready(key_ready), .overflow(overflow), .busy(busy),
    .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_data(lcd_data),
    .cur_line(cur_line), .cur_col(cur_col)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Bus monitor: one record per lcd_e pulse, pulse width and bus stability checked.
  logic       prev_e = 1'b0;
  int         width = 0;
  logic [8:0] rise_w = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_e = 1'b0;
      width  = 0;
    end else begin
      if (lcd_e) begin
        if (!prev_e) begin
          rise_w = {lcd_rs, lcd_data};
          got.push_back(rise_w);
          width = 0;
        end
        width++;
      end else if (prev_e) begin
        chk("e_width", 32'(width), 32'(E_PULSE));
        chk("bus_hold", 32'({lcd_rs, lcd_data}), 32'(rise_w));
      end
      prev_e = lcd_e;
    end
  end

  function automatic logic [7:0] ascii(input logic [3:0] k);
    string s;
    s = "0123456789ABCD*";
    return s.getc(int'(k));
  endfunction

  task automatic model_key(input logic [3:0] k);
    if (k == 4'hF) begin
      exp_q.push_back(9'h001);
      m_line = 0;
      m_col  = 0;
    end else begin
      if (m_col == LINE_LEN) begin
        exp_q.push_back((m_line != 0) ? 9'h080 : 9'h0C0);
        m_line = 1 - m_line;
        m_col  = 0;
      end
      exp_q.push_back({1'b1, ascii(k)});
      m_col++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    key_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(key_ready), 32'd0);
    chk("rst_bus", 32'({lcd_e, lcd_rs, lcd_data}), 32'd0);
    chk("rst_flags", 32'({busy, overflow}), 32'd0);
    chk("rst_cursor", 32'({cur_line, cur_col}), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(key_ready), 32'd1);
    got.delete();
    exp_q.delete();
    m_line = 0;
    m_col  = 0;
  endtask

  task automatic send_key(input logic [3:0] k);
    int n = 0;
    @(negedge clk);
    while (!key_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: key_ready=%0b, required 1 within 500 cycles", key_ready);
    end
    key_code  = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    model_key(k);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || lcd_e) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 3000) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy=%0b, required 0 within 3000 cycles", busy);
    end
  endtask

  task automatic compare_writes(input string name);
    chk({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk({name, "_write"}, 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic [3:0] key;
    logic [8:0] w;
    logic [4:0] col;
  } vec_t;

  vec_t       tbl[16];
  logic [3:0] burst_keys[6];
  logic [11:0] e_bits, b_bits;
  logic [5:0]  rdy_bits;
  int          ov_cnt;
  int          n;
  logic [3:0]  k;

  initial begin
    for (int i = 0; i < 10; i++) tbl[i] = '{4'(i), 9'h130 + 9'(i), 5'd1};
    tbl[10] = '{4'hA, 9'h141, 5'd1};
    tbl[11] = '{4'hB, 9'h142, 5'd1};
    tbl[12] = '{4'hC, 9'h143, 5'd1};
    tbl[13] = '{4'hD, 9'h144, 5'd1};
    tbl[14] = '{4'hE, 9'h12A, 5'd1};
    tbl[15] = '{4'hF, 9'h001, 5'd0};

    // Translation table, one key from reset each.
    for (int i = 0; i < 16; i++) begin
      do_reset();
      send_key(tbl[i].key);
      wait_idle();
      chk("tbl_count", 32'(got.size()), 32'd1);
      if (got.size() > 0) chk("tbl_write", 32'(got[0]), 32'(tbl[i].w));
      chk("tbl_col", 32'(cur_col), 32'(tbl[i].col));
      got.delete();
      exp_q.delete();
    end

    // Single key latency and pulse placement.
    do_reset();
    key_code  = 4'h7;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    e_bits = '0;
    b_bits = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e_bits[i] = lcd_e;
      b_bits[i] = busy;
      if (i == 2) chk("setup_bus", 32'({lcd_rs, lcd_data}), 32'h137);
      if (i == 9) chk("col_in_hold", 32'(cur_col), 32'd0);
    end
    chk("e_timing", 32'(e_bits), 32'h018);
    chk("busy_timing", 32'(b_bits), 32'h3FF);
    chk("col_after_7", 32'(cur_col), 32'd1);
    got.delete();

    // A..E: line fills, address write to line 1, then '*'.
    do_reset();
    for (int i = 10; i <= 14; i++) send_key(4'(i));
    wait_idle();
    compare_writes("abcde");
    chk("abcde_line", 32'(cur_line), 32'd1);
    chk("abcde_col", 32'(cur_col), 32'd1);

    // Clear after three characters with the long settle.
    do_reset();
    send_key(4'h1);
    send_key(4'h2);
    send_key(4'h3);
    send_key(4'hF);
    n = 0;
    @(negedge clk);
    while (!(got.size() == 4 && !lcd_e) && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("col_before_clr", 32'(cur_col), 32'd3);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("clr_hold", 32'(n), 32'(CLR_WAIT));
    chk("clr_cursor", 32'({cur_line, cur_col}), 32'd0);
    compare_writes("clear");

    // Burst of six back-to-back keys into an idle block.
    do_reset();
    burst_keys = '{4'h1, 4'h2, 4'hA, 4'h3, 4'hB, 4'h4};
    ov_cnt = 0;
    rdy_bits = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ov_cnt += int'(overflow);
      rdy_bits[i] = key_ready;
      key_code  = burst_keys[i];
      key_valid = 1'b1;
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j == 0) key_valid = 1'b0;
      ov_cnt += int'(overflow);
    end
    chk("burst_ready", 32'(rdy_bits), 32'h1F);
    chk("burst_overflow", 32'(ov_cnt), 32'd1);
    for (int i = 0; i < 5; i++) model_key(burst_keys[i]);
    wait_idle();
    compare_writes("burst");

    // Reset during PULSE discards the queue.
    do_reset();
    send_key(4'h1);
    send_key(4'h2);
    send_key(4'h3);
    n = 0;
    @(negedge clk);
    while (!lcd_e && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("pulse_seen", 32'(lcd_e), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_e", 32'(lcd_e), 32'd0);
    chk("midrst_bus", 32'({lcd_rs, lcd_data}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cursor", 32'({cur_line, cur_col}), 32'd0);
    rst = 1'b0;
    got.delete();
    exp_q.delete();
    m_line = 0;
    m_col  = 0;
    repeat (30) @(negedge clk);
    chk("midrst_no_writes", 32'(got.size()), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);
    send_key(4'h5);
    wait_idle();
    compare_writes("post_rst");
    chk("post_rst_col", 32'(cur_col), 32'd1);

    // Eight digits fill both lines; the wrap to line 0 waits for a ninth key.
    do_reset();
    for (int i = 0; i < 8; i++) send_key(4'(i));
    wait_idle();
    compare_writes("digits");
    chk("digits_line", 32'(cur_line), 32'(m_line));
    chk("digits_col", 32'(cur_col), 32'd4);
    send_key(4'h8);
    wait_idle();
    compare_writes("wrap");
    chk("wrap_line", 32'(cur_line), 32'd0);
    chk("wrap_col", 32'(cur_col), 32'd1);

    // Randomized key streams.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int j = 0; j < 16; j++) begin
        if ($urandom_range(0, 7) == 0) k = 4'hF;
        else k = 4'($urandom_range(0, 14));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if ($urandom_range(0, 5) == 0) repeat (20) @(negedge clk);
        send_key(k);
      end
      wait_idle();
      compare_writes("rand");
      chk("rand_line", 32'(cur_line), 32'(m_line));
      chk("rand_col", 32'(cur_col), 32'(m_col));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/keypad_lcd_writer.md
Name: keypad_lcd_writer

Overview:
- Sequences 4-bit keypad codes onto an HD44780-style LCD in 8-bit mode.
- Buffers incoming key events in a small FIFO and translates each code to an RS/data character.
- Generates RS/E/DATA bus timing with programmable pulse and settle waits, and tracks the cursor across two lines.
- Sits between the keypad decoder and the LCD pins in the parking front panel.

Parameters:
- E_PULSE, 12, cycles lcd_e is held high per write (≥1)
- CHAR_WAIT, 2000, settle cycles after a character or address write (≥1)
- CLR_WAIT, 80000, settle cycles after a clear-display command (≥1)
- FIFO_DEPTH, 4, key FIFO entries (power of 2, ≥2)
- LINE_LEN, 16, characters per LCD line

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- key_code  input  4  keypad code
- key_valid  input  1  key_code valid this cycle
- key_ready  output  1  FIFO not full; a key is accepted when key_valid & key_ready
- overflow  output  1  1-cycle pulse when key_valid is high while key_ready is low (key dropped)
- busy  output  1  FSM not in IDLE, or FIFO not empty
- lcd_rs  output  1  0 = command, 1 = data
- lcd_e  output  1  LCD enable strobe
- lcd_data  output  8  LCD data bus
- cur_line  output  1  current cursor line
- cur_col  output  5  current cursor column, 0..LINE_LEN

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high; all state is registered.
- Reset values:
  - lcd_e=0, lcd_rs=0, lcd_data=0, busy=0, overflow=0.
  - cur_line=0, cur_col=0, FIFO empty, FSM=IDLE.
  - key_ready=0 while rst is high, 1 in the first cycle after rst falls.
  - rst mid-write drops lcd_e in the next cycle and discards FIFO contents.
- FIFO:
  - key_ready = !full, from the registered count.
  - Push and pop in the same cycle leave the count unchanged.
  - A push while full is ignored and raises overflow.
- Key translation (bit 8 = RS):
  - 0..9 → 0x130..0x139
  - A..D (4'hA..4'hD) → 0x141..0x144
  - 4'hE → 0x12A ('*')
  - 4'hF → clear action, not printed.
- FSM states: IDLE, LOAD, ADDR, SETUP, PULSE, HOLD.
  - IDLE: FIFO not empty → LOAD.
  - LOAD: pops one key. Next state:
    - 4'hF → SETUP with {rs=0, data=0x01}, wait=CLR_WAIT.
    - else if cur_col==LINE_LEN → ADDR.
    - else → SETUP with the character, wait=CHAR_WAIT.
  - ADDR: loads {rs=0, data = cur_line ? 0x80 : 0xC0}, wait=CHAR_WAIT, then → SETUP. The popped character is retained and written after the address write completes (second SETUP/PULSE/HOLD pass).
  - SETUP: one cycle; lcd_rs/lcd_data are driven, lcd_e=0.
  - PULSE: lcd_e=1 for exactly E_PULSE cycles; lcd_rs/lcd_data are held.
  - HOLD: lcd_e=0 for the selected wait count. lcd_data/lcd_rs hold their last value until the next SETUP.
  - At HOLD end, cursor update:
    - clear → cur_line=0, cur_col=0.
    - address write → cur_line toggles, cur_col=0.
    - character → cur_col+1.
  - Then → pending character SETUP, or LOAD if FIFO is non-empty, else IDLE.
- Line wrap: a full line does not move the cursor until the next printable key arrives. Line 1 full wraps to line 0 (address 0x80).
- Latency: key accepted at cycle N into an empty FIFO, IDLE FSM → LOAD at N+1, SETUP at N+2, lcd_e high N+3..N+2+E_PULSE.
- Throughput: one write per 1+E_PULSE+wait cycles (plus LOAD).

Test Plan:
Bench parameters: E_PULSE=2, CHAR_WAIT=5, CLR_WAIT=20, LINE_LEN=4, FIFO_DEPTH=4.
- Single key 4'h7 after reset → rs=1, data=0x37, lcd_e high exactly 2 cycles starting 3 cycles after acceptance; cur_col=1; busy falls after HOLD.
- Keys A,B,C,D,E → data 0x41,0x42,0x43,0x44, then rs=0 data=0xC0, then rs=1 data=0x2A; final cur_line=1, cur_col=1.
- Key F after 3 chars → rs=0 data=0x01, 20-cycle HOLD, then cur_line=0, cur_col=0.
- Burst of 6 back-to-back key_valid into an idle block → first 4 (plus any popped meanwhile) accepted with key_ready low when full; overflow pulses once per dropped key; accepted keys are output in order.
- rst asserted during PULSE → next cycle lcd_e=0, outputs and cursor zero, FIFO empty; a key sent after rst falls prints normally.
- 8 digits 0..7 → line 1 wrap to 0x80 after the 8th digit only when a 9th key arrives; cur_col=4, cur_line=1 at idle.
